// File: rtl/alu_decode_stage.sv
// RV32I decode stage: turns one instruction word + PC into a registered ALU
// command (opcode, operand selects, immediate, register indices) behind a valid/ready register.
module alu_decode_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_insn,
  input  logic [WIDTH-1:0] i_pc,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [3:0]       o_alu_op,
  output logic [1:0]       o_opa_sel,
  output logic             o_opb_sel,
  output logic [WIDTH-1:0] o_imm,
  output logic [4:0]       o_rs1_addr,
  output logic [4:0]       o_rs2_addr,
  output logic [4:0]       o_rd_addr,
  output logic             o_rd_wren,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_insn_vld
);

  // ALU opcode encoding shared with the execute stage
  localparam logic [3:0] ALU_ADD  = 4'b0000;

  localparam logic [1:0] OPA_RS1  = 2'd0;
  localparam logic [1:0] OPA_PC   = 2'd1;
  localparam logic [1:0] OPA_ZERO = 2'd2;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011
  } opcode_e;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = i_insn[6:0];
  assign funct3 = i_insn[14:12];
  assign funct7 = i_insn[31:25];
  assign rd     = i_insn[11:7];

  logic [WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{i_insn[31]}}, i_insn[31:20]};
  assign imm_s = {{20{i_insn[31]}}, i_insn[31:25], i_insn[11:7]};
  assign imm_b = {{19{i_insn[31]}}, i_insn[31], i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0};
  assign imm_u = {i_insn[31:12], 12'b0};
  assign imm_j = {{11{i_insn[31]}}, i_insn[31], i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0};

  logic [3:0]       d_alu_op;
  logic [1:0]       d_opa_sel;
  logic             d_opb_sel;
  logic [WIDTH-1:0] d_imm;
  logic             d_wren;
  logic             d_legal;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    d_alu_op  = ALU_ADD;
    d_opa_sel = OPA_RS1;
    d_opb_sel = 1'b1;
    d_imm     = '0;
    d_wren    = 1'b1;
    d_legal   = 1'b1;

    case (opcode)
      OPC_OP: begin
        d_alu_op  = {i_insn[30], funct3};
        d_opb_sel = 1'b0;
        d_legal   = (funct7 == 7'b0000000) ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OPC_OP_IMM: begin
        d_imm    = imm_i;
        d_alu_op = (funct3 == 3'b101) ? {i_insn[30], funct3} : {1'b0, funct3};
        // Shift-immediates reuse insn[31:25] as a funct7 that must be well formed
        if (funct3 == 3'b001)
          d_legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101)
          d_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
      end
      OPC_LUI: begin
        d_imm     = imm_u;
        d_opa_sel = OPA_ZERO;
      end
      OPC_AUIPC: begin
        d_imm     = imm_u;
        d_opa_sel = OPA_PC;
      end
      OPC_JAL: begin
        d_imm     = imm_j;
        d_opa_sel = OPA_PC;
      end
      OPC_JALR: begin
        d_imm   = imm_i;
        d_legal = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        d_imm     = imm_b;
        d_opa_sel = OPA_PC;
        d_wren    = 1'b0;
        d_legal   = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OPC_LOAD: begin
        d_imm   = imm_i;
        d_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      OPC_STORE: begin
        d_imm   = imm_s;
        d_wren  = 1'b0;
        d_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
      default: d_legal = 1'b0;
    endcase

    // Illegal words travel down as an inert ADD with no writeback
    if (!d_legal) begin
      d_alu_op  = ALU_ADD;
      d_opa_sel = OPA_RS1;
      d_opb_sel = 1'b0;
      d_imm     = '0;
      d_wren    = 1'b0;
    end
    if (rd == 5'd0)
      d_wren = 1'b0;
  end

  logic accept;

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready && !i_flush;

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_rst) begin
      // NOTE: only the output register exists, so every bit of it is reset explicitly.
      o_valid    <= 1'b0;
      o_alu_op   <= '0;
      o_opa_sel  <= '0;
      o_opb_sel  <= 1'b0;
      o_imm      <= '0;
      o_rs1_addr <= '0;
      o_rs2_addr <= '0;
      o_rd_addr  <= '0;
      o_rd_wren  <= 1'b0;
      o_pc       <= RESET_PC;
      o_insn_vld <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid    <= 1'b1;
      o_alu_op   <= d_alu_op;
      o_opa_sel  <= d_opa_sel;
      o_opb_sel  <= d_opb_sel;
      o_imm      <= d_imm;
      o_rs1_addr <= i_insn[19:15];
      o_rs2_addr <= i_insn[24:20];
      o_rd_addr  <= rd;
      o_rd_wren  <= d_wren;
      o_pc       <= i_pc;
      o_insn_vld <= d_legal;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
